// File: rtl/serial_bit_feeder.sv
// serial_bit_feeder
// Parallel-to-serial front end for the 1011 sequence detector. Words arrive
// over a valid/ready handshake into a one-word holding register and are
// shifted out one bit every DIV clock cycles. A held word is loaded into the
// shifter at the edge that ends the previous word's last bit, so back-to-back
// words are serialized without an idle cycle between them.
//
// Parameters:
//   WIDTH     word width in bits (>= 2)
//   DIV       clock cycles per serial bit (>= 1)
//   MSB_FIRST 1: bit WIDTH-1 goes out first, 0: bit 0 goes out first
//
// Ports:
//   clk           clock, all state changes on the rising edge
//   rst_n         asynchronous active-low reset
//   in_data_i     parallel word to serialize
//   in_valid_i    in_data_i is valid
//   in_ready_o    feeder accepts a word this cycle
//   bit_out_o     serial data bit (0 while idle)
//   bit_valid_o   bit_out_o carries word data
//   bit_strobe_o  pulse in the first cycle of every bit period
//   word_done_o   pulse in the final cycle of a word's last bit period
//   busy_o        shifter active or holding register full
module serial_bit_feeder #(
    parameter int WIDTH     = 8,
    parameter int DIV       = 1,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic             bit_out_o,
    output logic             bit_valid_o,
    output logic             bit_strobe_o,
    output logic             word_done_o,
    output logic             busy_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] BIT_MAX = CW'(WIDTH - 1);
    localparam logic [DW-1:0] DIV_MAX = DW'(DIV - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [DW-1:0]    div_cnt_q, div_cnt_d;

    logic last;
    logic load;
    logic accept;
    logic [WIDTH-1:0] sh_shifted;

    // last marks the final cycle of the final bit; a held word may load on
    // that edge, which is what keeps consecutive words gapless.
    assign last   = (state_q == SHIFT) && (bit_cnt_q == BIT_MAX) && (div_cnt_q == DIV_MAX);
    assign load   = hold_full_q && ((state_q == IDLE) || last);
    assign accept = in_valid_i && in_ready_o;

    // in_ready depends on registered state only, never on in_valid.
    assign in_ready_o = !hold_full_q || load;

    assign sh_shifted = (MSB_FIRST != 0) ? {sh_q[WIDTH-2:0], 1'b0}
                                         : {1'b0, sh_q[WIDTH-1:1]};

    // Next-state logic. A load empties the holding register, but an accept in
    // the same cycle refills it with the new word, so accept is applied last.
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        sh_d        = sh_q;
        bit_cnt_d   = bit_cnt_q;
        div_cnt_d   = div_cnt_q;

        if (load) begin
            sh_d        = hold_q;
            bit_cnt_d   = '0;
            div_cnt_d   = '0;
            state_d     = SHIFT;
            hold_full_d = 1'b0;
        end else if (state_q == SHIFT) begin
            if (last) begin
                state_d   = IDLE;
                bit_cnt_d = '0;
                div_cnt_d = '0;
            end else if (div_cnt_q == DIV_MAX) begin
                div_cnt_d = '0;
                bit_cnt_d = bit_cnt_q + CW'(1);
                sh_d      = sh_shifted;
            end else begin
                div_cnt_d = div_cnt_q + DW'(1);
            end
        end

        if (accept) begin
            hold_d      = in_data_i;
            hold_full_d = 1'b1;
        end
    end

    // State registers; reset discards any partial or held word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            sh_q        <= '0;
            bit_cnt_q   <= '0;
            div_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            sh_q        <= sh_d;
            bit_cnt_q   <= bit_cnt_d;
            div_cnt_q   <= div_cnt_d;
        end
    end

    // Idle zeros keep the downstream detector in its start state.
    assign bit_out_o    = (state_q == SHIFT) &&
                          ((MSB_FIRST != 0) ? sh_q[WIDTH-1] : sh_q[0]);
    assign bit_valid_o  = (state_q == SHIFT);
    assign bit_strobe_o = (state_q == SHIFT) && (div_cnt_q == '0);
    assign word_done_o  = last;
    assign busy_o       = (state_q == SHIFT) || hold_full_q;

endmodule

// File: tb/tb_serial_bit_feeder.sv
// tb_serial_bit_feeder
// Two feeder instances: instance 0 is WIDTH=8, DIV=1, MSB first; instance 1
// is WIDTH=8, DIV=3, LSB first. Accepted words are expanded by a timeline
// model into one expected entry per serial cycle and queued; a monitor on
// the falling edge pops entries as the feeder presents them and also checks
// in_ready and busy against the model's occupancy.
module tb_serial_bit_feeder;

    localparam int W    = 8;
    localparam int DIV0 = 1;
    localparam int DIV1 = 3;

    typedef struct {
        int   cyc;
        logic b;
        logic s;
        logic d;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] inData   [2];
    logic         inValid  [2];
    logic         inReady  [2];
    logic         bitOut   [2];
    logic         bitValid [2];
    logic         bitStrobe[2];
    logic         wordDone [2];
    logic         busy     [2];

    int   cyc;
    int   checks;
    int   failures;
    int   nextFree [2];
    int   lastStart[2];
    exp_t q0[$];
    exp_t q1[$];

    exp_t monE;
    logic monHave;

    serial_bit_feeder #(.WIDTH(W), .DIV(DIV0), .MSB_FIRST(1)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_data_i(inData[0]), .in_valid_i(inValid[0]), .in_ready_o(inReady[0]),
        .bit_out_o(bitOut[0]), .bit_valid_o(bitValid[0]), .bit_strobe_o(bitStrobe[0]),
        .word_done_o(wordDone[0]), .busy_o(busy[0])
    );

    serial_bit_feeder #(.WIDTH(W), .DIV(DIV1), .MSB_FIRST(0)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_data_i(inData[1]), .in_valid_i(inValid[1]), .in_ready_o(inReady[1]),
        .bit_out_o(bitOut[1]), .bit_valid_o(bitValid[1]), .bit_strobe_o(bitStrobe[1]),
        .word_done_o(wordDone[1]), .busy_o(busy[1])
    );

    // 10 ns clock; cyc counts rising edges, so the cycle after edge n is n.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Expand a word accepted at edge cyc into per-cycle expectations. The word
    // starts serializing one cycle after acceptance, or right after the
    // previous word ends if the shifter is still busy.
    task automatic pushWord(input int i, input logic [W-1:0] w);
        int   d;
        int   s;
        exp_t e;
        d = (i == 0) ? DIV0 : DIV1;
        s = (cyc + 1 > nextFree[i]) ? cyc + 1 : nextFree[i];
        for (int k = 0; k < W; k++) begin
            for (int j = 0; j < d; j++) begin
                e.cyc = s + k * d + j;
                e.b   = (i == 0) ? w[W-1-k] : w[k];
                e.s   = (j == 0);
                e.d   = (k == W - 1) && (j == d - 1);
                if (i == 0) q0.push_back(e);
                else        q1.push_back(e);
            end
        end
        nextFree[i]  = s + W * d;
        lastStart[i] = s;
    endtask

    // Called just after a rising edge; offers a word until it is accepted and
    // returns just after the accepting edge with in_valid still high.
    task automatic applyStimulus(input int i, input logic [W-1:0] w);
        logic rdy;
        int   guard;
        inValid[i] = 1'b1;
        inData[i]  = w;
        guard      = 0;
        rdy        = 1'b0;
        while (!rdy && guard < 200) begin
            @(negedge clk);
            rdy = inReady[i];
            @(posedge clk);
            #1;
            guard++;
        end
        if (rdy) pushWord(i, w);
        else begin
            checkOutput($sformatf("acceptTimeout%0d", i), 0, 1);
            inValid[i] = 1'b0;
        end
    endtask

    task automatic idle(input int i, input int n);
        inValid[i] = 1'b0;
        inData[i]  = $urandom;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clearModel();
        q0.delete();
        q1.delete();
        for (int i = 0; i < 2; i++) begin
            nextFree[i]  = 0;
            lastStart[i] = 0;
        end
    endtask

    // Monitor: pop the expected entry for this cycle if one is due, otherwise
    // the feeder must present idle zeros.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            monHave = 1'b0;
            monE    = '{cyc, 1'b0, 1'b0, 1'b0};
            if (i == 0) begin
                if (q0.size() > 0 && q0[0].cyc < cyc) begin
                    checkOutput("staleEntry0", q0[0].cyc, cyc);
                    void'(q0.pop_front());
                end
                if (q0.size() > 0 && q0[0].cyc == cyc) begin
                    monE    = q0.pop_front();
                    monHave = 1'b1;
                end
            end else begin
                if (q1.size() > 0 && q1[0].cyc < cyc) begin
                    checkOutput("staleEntry1", q1[0].cyc, cyc);
                    void'(q1.pop_front());
                end
                if (q1.size() > 0 && q1[0].cyc == cyc) begin
                    monE    = q1.pop_front();
                    monHave = 1'b1;
                end
            end
            checkOutput($sformatf("bitValid%0d", i), int'(bitValid[i]), int'(monHave));
            checkOutput($sformatf("bitOut%0d", i), int'(bitOut[i]), int'(monE.b));
            checkOutput($sformatf("bitStrobe%0d", i), int'(bitStrobe[i]), int'(monE.s));
            checkOutput($sformatf("wordDone%0d", i), int'(wordDone[i]), int'(monE.d));
            checkOutput($sformatf("inReady%0d", i), int'(inReady[i]), int'(lastStart[i] <= cyc + 1));
            checkOutput($sformatf("busy%0d", i), int'(busy[i]), int'(cyc < nextFree[i]));
        end
    end

    initial begin
        int guard;
        checks   = 0;
        failures = 0;
        clearModel();
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            inValid[i] = 1'b0;
            inData[i]  = '0;
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] single word 8'hB0, then back-to-back B0 B0 0B");
        applyStimulus(0, 8'hB0);
        idle(0, 12);
        applyStimulus(0, 8'hB0);
        applyStimulus(0, 8'hB0);
        applyStimulus(0, 8'h0B);
        idle(0, 20);

        $display("[TB] random words with random gaps on instance 0");
        for (int n = 0; n < 20; n++) begin
            applyStimulus(0, W'($urandom));
            idle(0, $urandom_range(0, 10));
        end
        idle(0, 20);

        $display("[TB] reset mid-word with a word held");
        applyStimulus(0, 8'hFF);
        applyStimulus(0, 8'h3C);
        idle(0, 4);
        #2;
        rst_n = 1'b0;
        clearModel();
        #1;
        checkOutput("rstBitOut", int'(bitOut[0]), 0);
        checkOutput("rstBitValid", int'(bitValid[0]), 0);
        checkOutput("rstBusy", int'(busy[0]), 0);
        checkOutput("rstInReady", int'(inReady[0]), 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(0, 8'h80);
        idle(0, 12);

        $display("[TB] DIV=3 LSB-first instance: A5, 0D, random words");
        applyStimulus(1, 8'hA5);
        idle(1, 30);
        applyStimulus(1, 8'h0D);
        applyStimulus(1, 8'hA5);
        idle(1, 5);
        for (int n = 0; n < 12; n++) begin
            applyStimulus(1, W'($urandom));
            idle(1, $urandom_range(0, 30));
        end

        guard = 0;
        while ((q0.size() != 0 || q1.size() != 0) && guard < 2000) begin
            @(posedge clk);
            guard++;
        end
        repeat (3) @(posedge clk);
        checkOutput("drainEmpty", q0.size() + q1.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_bit_feeder.md
# serial_bit_feeder

Parallel-to-serial front end for the 1011 sequence-detector stage. It accepts WIDTH-bit words over a valid/ready handshake and buffers one word in a holding register. It shifts each word out one bit per DIV clock cycles, gaplessly when words arrive back-to-back. The serial output drives the downstream detector's data input; a strobe marks each new bit for detectors running at DIV>1.

## Interface
- WIDTH, 8: word width in bits, ≥2.
- DIV, 1: clock cycles per serial bit, ≥1.
- MSB_FIRST, 1: 1 shifts bit WIDTH-1 first; 0 shifts bit 0 first.

- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_data  in  WIDTH  parallel word to serialize.
- in_valid  in  1  in_data valid.
- in_ready  out  1  feeder can accept a word this cycle.
- bit_out  out  1  serial data bit to detector.
- bit_valid  out  1  bit_out carries word data.
- bit_strobe  out  1  one-cycle pulse in the first cycle of each bit period.
- word_done  out  1  one-cycle pulse in the final cycle of a word's last bit period.
- busy  out  1  shifter active or holding register full.

## Operation
- Storage:
  - holding register hold_q plus hold_full flag;
  - shift register sh_q;
  - bit counter bit_cnt, 0..WIDTH-1;
  - divider counter div_cnt, 0..DIV-1.
- FSM states: IDLE (shifter empty) and SHIFT (bit period in progress).
- Accept: transfer occurs when in_valid && in_ready at a rising edge. The word is written to hold_q and hold_full is set.
- in_ready = !hold_full || load. It is combinational from registered state only and has no path from in_valid.
- load = hold_full && (state==IDLE || last), where last = (state==SHIFT && bit_cnt==WIDTH-1 && div_cnt==DIV-1).
- On load:
  - sh_q <= hold_q; bit_cnt <= 0; div_cnt <= 0; state <= SHIFT.
  - hold_full clears unless a new word is accepted in the same cycle. Accept wins, and hold_q takes the new word.
- In SHIFT without last:
  - div_cnt increments.
  - When div_cnt==DIV-1: div_cnt <= 0, bit_cnt increments, and sh_q shifts toward the output end.
- On last with !hold_full: state <= IDLE, counters clear.
- bit_out = output end of sh_q (MSB or LSB per MSB_FIRST) when state==SHIFT; 0 in IDLE. Idle zeros keep the detector in its start state.
- bit_valid = (state==SHIFT).
- bit_strobe = (state==SHIFT && div_cnt==0).
- word_done = last.
- busy = (state==SHIFT) || hold_full.
- Reset, including mid-word: state=IDLE, hold_full=0, counters=0, sh_q=0. The partial word is discarded.
- Outputs during and after reset: in_ready=1, bit_out=0, bit_valid=0, bit_strobe=0, word_done=0, busy=0.

## Timing
- Latency: word accepted at edge E0; loaded into the shifter at E0+1.
- Bit k (k=0..WIDTH-1) is on bit_out for cycles E0+1+k·DIV through E0+(k+1)·DIV.
- The feeder sustains the full serial rate:
  - a word offered while the previous word is shifting is accepted into hold_q;
  - it loads at the edge ending the previous last bit, with no idle cycle between words.
- With hold_full=1 and no load, in_ready=0. in_data must be held stable by the producer until accepted.
- Exactly one bit_strobe per bit and one word_done per word. With DIV=1, bit_strobe is high every SHIFT cycle.
- Deassertion of rst_n takes effect at the first rising edge after release. A word offered in that cycle is accepted.

## Test plan
- Single word, WIDTH=8, DIV=1, MSB_FIRST=1, in_data=8'hB0 accepted at E0:
  - bit_out=1,0,1,1,0,0,0,0 on cycles E0+1..E0+8;
  - word_done in cycle E0+8;
  - bit_out=0 and bit_valid=0 from E0+9.
- Back-to-back 8'hB0, 8'hB0, 8'h0B with in_valid held high:
  - 24 consecutive bit_valid cycles with no gap;
  - in_ready low while hold_full and no load;
  - three word_done pulses, 8 cycles apart.
- DIV=3, in_data=8'hA5: each bit held 3 cycles; bit_strobe pulses at offsets 0,3,…,21; 8 strobes total; word_done in cycle 24.
- MSB_FIRST=0, in_data=8'h0D: bit_out sequence 1,0,1,1,0,0,0,0.
- Reset asserted mid-word, at bit 4 of 8'hFF with a second word in hold:
  - immediately bit_out=0, bit_valid=0, busy=0, in_ready=1;
  - after release, a new 8'h80 serializes as 1 then seven 0s.
- Simultaneous load and accept: a new word is offered in the final cycle of the previous word while hold is full:
  - in_ready=1 in that cycle;
  - the held word loads and the new word fills hold_q;
  - no word is lost or duplicated.
